// File: rtl/tdc_sign_mag.sv
// rtl/tdc_sign_mag.sv - time-to-digital decoder: pulse width plus sign level to saturated two's-complement word (optional glitch filter: TDC_GLITCH_FILTER_EN)

module tdc_sign_mag #(
    parameter int DW      = 8,
    parameter int CNT_W   = 9,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic          tac_in,
    input  logic          sign_in,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          ovf,
    output logic          busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    // Clip limits expressed in the internal CNT_W+1 signed domain
    localparam logic signed [CNT_W:0] POS_LIM = $signed((CNT_W + 1)'((1 << (DW - 1)) - 1));
    localparam logic signed [CNT_W:0] NEG_LIM = $signed((CNT_W + 1)'(1 << (DW - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COUNT
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                sat_q, sat_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic signed [CNT_W:0] conv_mag;
    logic signed [CNT_W:0] conv_val;
    logic                  conv_clip;
    logic                  is_glitch;

    // A single-sample pulse is only discarded when the filter is built in
`ifdef TDC_GLITCH_FILTER_EN
    assign is_glitch = (cnt_q == CNT_ONE);
`else
    assign is_glitch = 1'b0;
`endif

    // Clip the measured magnitude to the signed output range and apply the sign
    always_comb begin
        conv_mag  = $signed({1'b0, cnt_q});
        conv_clip = 1'b0;
        conv_val  = '0;
        if (sign_q) begin
            if (conv_mag > NEG_LIM) begin
                conv_mag  = NEG_LIM;
                conv_clip = 1'b1;
            end
            conv_val = -conv_mag;
        end else begin
            if (conv_mag > POS_LIM) begin
                conv_mag  = POS_LIM;
                conv_clip = 1'b1;
            end
            conv_val = conv_mag;
        end
    end

    // Next-state and datapath updates for the IDLE/ARMED/COUNT sequence
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        sat_d   = sat_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_ARMED;
                    wait_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            S_ARMED: begin
                if (tac_in) begin
                    state_d = S_COUNT;
                    cnt_d   = CNT_ONE;
                    sign_d  = sign_in;
                    sat_d   = 1'b0;
                end else if (wait_q >= WAIT_LAST) begin
                    state_d = S_IDLE;
                    dout_d  = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_COUNT: begin
                if (tac_in) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (is_glitch) begin
                    // Wait counter deliberately keeps its value across the glitch
                    state_d = S_ARMED;
                    sign_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    dout_d  = conv_val[DW-1:0];
                    ovf_d   = conv_clip | sat_q;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sat_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            sat_q   <= sat_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q != S_IDLE);

endmodule
